// File: rtl/crc_field.sv
// CAN CRC-15 stage: accumulates over SOF..data bits, then serialises the CRC MSB-first and the recessive delimiter.
// All outputs are registered. Each step waits for an unstuffed sample point. There is no backpressure path.
module crc_field #(
  parameter int                   CRC_WIDTH = 15,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 15'h4599
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sample_point,
  input  logic                 stuff_bit_inserted,
  input  logic                 frame_start,
  input  logic                 frame_bit,
  input  logic                 data_complete,
  output logic                 crc_bit,
  output logic [CRC_WIDTH-1:0] crc_value,
  output logic [3:0]           bit_counter,
  output logic                 crc_complete
);

  typedef enum logic [2:0] {
    IDLE,
    ACCUMULATE,
    LOAD_CRC,
    TRANSMIT_CRC,
    DELIMITER,
    COMPLETE
  } state_t;

  localparam logic [3:0] LAST_BIT  = 4'(CRC_WIDTH - 1);
  localparam logic [3:0] ALL_SENT  = 4'(CRC_WIDTH);

  state_t                 state_q, state_d;
  logic [CRC_WIDTH-1:0]   crc_q, crc_d;
  logic [CRC_WIDTH-1:0]   shift_q, shift_d;
  logic                   crc_bit_q, crc_bit_d;
  logic [3:0]             bit_counter_q, bit_counter_d;
  logic                   crc_complete_q, crc_complete_d;
  logic                   qbit;
  logic                   nxt;
  logic [CRC_WIDTH-1:0]   crc_next;

  assign qbit = sample_point && !stuff_bit_inserted;

  always_comb begin
    nxt      = frame_bit ^ crc_q[CRC_WIDTH-1];
    crc_next = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (nxt ? CRC_POLY : '0);
  end

  always_comb begin
    state_d        = state_q;
    crc_d          = crc_q;
    shift_d        = shift_q;
    crc_bit_d      = crc_bit_q;
    bit_counter_d  = bit_counter_q;
    crc_complete_d = 1'b0;

    if (!enable) begin
      state_d       = IDLE;
      crc_d         = '0;
      shift_d       = '0;
      crc_bit_d     = 1'b1;
      bit_counter_d = '0;
    end else if (frame_start) begin
      // A new SOF always restarts accumulation, aborting whatever was in flight
      state_d       = ACCUMULATE;
      crc_d         = '0;
      shift_d       = '0;
      crc_bit_d     = 1'b1;
      bit_counter_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          crc_bit_d     = 1'b1;
          bit_counter_d = '0;
        end
        ACCUMULATE: begin
          if (data_complete) begin
            state_d = LOAD_CRC;
          end else if (qbit) begin
            crc_d = crc_next;
          end
        end
        LOAD_CRC: begin
          shift_d       = crc_q;
          crc_bit_d     = crc_q[CRC_WIDTH-1];
          bit_counter_d = '0;
          state_d       = TRANSMIT_CRC;
        end
        TRANSMIT_CRC: begin
          if (qbit) begin
            shift_d = shift_q << 1;
            if (bit_counter_q == LAST_BIT) begin
              bit_counter_d = ALL_SENT;
              crc_bit_d     = 1'b1;
              state_d       = DELIMITER;
            end else begin
              bit_counter_d = bit_counter_q + 4'd1;
              crc_bit_d     = shift_q[CRC_WIDTH-2];
            end
          end
        end
        DELIMITER: begin
          crc_bit_d = 1'b1;
          if (qbit) begin
            state_d        = COMPLETE;
            crc_complete_d = 1'b1;
          end
        end
        COMPLETE: begin
          crc_bit_d = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      crc_q          <= '0;
      shift_q        <= '0;
      crc_bit_q      <= 1'b1;
      bit_counter_q  <= '0;
      crc_complete_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      crc_q          <= crc_d;
      shift_q        <= shift_d;
      crc_bit_q      <= crc_bit_d;
      bit_counter_q  <= bit_counter_d;
      crc_complete_q <= crc_complete_d;
    end
  end

  assign crc_bit      = crc_bit_q;
  assign crc_value    = crc_q;
  assign bit_counter  = bit_counter_q;
  assign crc_complete = crc_complete_q;

endmodule

// File: tb/tb_crc_field.sv
// Directed bench for crc_field.
// The expected CRC comes from polynomial long division of the accumulated bits, with outputs compared on every falling edge.
module tb_crc_field;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_point;
  logic        stuff_bit_inserted;
  logic        frame_start;
  logic        frame_bit;
  logic        data_complete;
  logic        crc_bit;
  logic [14:0] crc_value;
  logic [3:0]  bit_counter;
  logic        crc_complete;

  int          checks   = 0;
  int          failures = 0;
  int          pulses   = 0;

  // expected outputs, maintained by the stimulus tasks; e_cnt < 0 means don't care
  logic        e_bit;
  logic        e_cmp;
  logic [14:0] e_val;
  int          e_cnt;
  bit          mq[$];
  bit          obs[$];

  always #5 clock = ~clock;

  crc_field dut (
    .clock              (clock),
    .reset              (reset),
    .enable             (enable),
    .sample_point       (sample_point),
    .stuff_bit_inserted (stuff_bit_inserted),
    .frame_start        (frame_start),
    .frame_bit          (frame_bit),
    .data_complete      (data_complete),
    .crc_bit            (crc_bit),
    .crc_value          (crc_value),
    .bit_counter        (bit_counter),
    .crc_complete       (crc_complete)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // remainder of M(x) * x^15 divided by G(x) = x^15 + 0x4599
  function automatic logic [14:0] crc_model(input bit m[$]);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < m.size() + 15; i++) begin
      r = {r[14:0], (i < m.size()) ? m[i] : 1'b0};
      if (r[15]) r = r ^ {1'b1, 15'h4599};
    end
    return r[14:0];
  endfunction

  function automatic logic [15:0] packed_obs();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < obs.size() && i < 16; i++) v[15-i] = obs[i];
    return v;
  endfunction

  always @(negedge clock) begin
    check("crc_bit", 32'(crc_bit), 32'(e_bit));
    check("crc_value", 32'(crc_value), 32'(e_val));
    check("crc_complete", 32'(crc_complete), 32'(e_cmp));
    if (e_cnt >= 0) check("bit_counter", 32'(bit_counter), e_cnt);
    if (crc_complete === 1'b1) pulses++;
  end

  task automatic step(input bit sp, input bit stf, input bit fs, input bit fb, input bit dc);
    sample_point       = sp;
    stuff_bit_inserted = stf;
    frame_start        = fs;
    frame_bit          = fb;
    data_complete      = dc;
    @(posedge clock);
    #1;
    sample_point       = 1'b0;
    stuff_bit_inserted = 1'b0;
    frame_start        = 1'b0;
    frame_bit          = 1'b0;
    data_complete      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic set_reset_expect();
    e_bit = 1'b1;
    e_val = '0;
    e_cnt = 0;
    e_cmp = 1'b0;
  endtask

  task automatic start_frame();
    step(0, 0, 1, 0, 0);
    mq.delete();
    set_reset_expect();
    idle(1);
  endtask

  task automatic acc(input bit b, input bit stf);
    step(1, stf, 0, b, 0);
    if (!stf) begin
      mq.push_back(b);
      e_val = crc_model(mq);
    end
    idle(2);
  endtask

  // data_complete, load, then qbits 1..stop_after (16 reaches COMPLETE)
  task automatic transmit(input int n_stuff, input int stop_after);
    logic [14:0] w;
    int          s;
    w = e_val;
    s = 0;
    obs.delete();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    e_bit = w[14];
    e_cnt = 0;
    obs.push_back(crc_bit);
    idle(1);
    for (int k = 1; k <= stop_after; k++) begin
      if (k % 4 == 0 && s < n_stuff) begin
        step(1, 1, 0, 1, 0);
        s++;
        idle(2);
      end
      step(1, 0, 0, 0, 0);
      if (k <= 14) begin
        e_bit = w[14-k];
        e_cnt = k;
      end else if (k == 15) begin
        e_bit = 1'b1;
        e_cnt = 15;
      end else begin
        e_cmp = 1'b1;
      end
      if (k <= 15) obs.push_back(crc_bit);
      if (k == 16) begin
        step(0, 0, 0, 0, 0);
        e_cmp = 1'b0;
        e_cnt = -1;
        step(0, 0, 0, 0, 0);
        e_cnt = 0;
      end else begin
        idle(2);
      end
    end
  endtask

  initial begin
    int p0;
    reset              = 1'b1;
    enable             = 1'b1;
    sample_point       = 1'b0;
    stuff_bit_inserted = 1'b0;
    frame_start        = 1'b0;
    frame_bit          = 1'b0;
    data_complete      = 1'b0;
    set_reset_expect();
    idle(2);
    reset = 1'b0;
    idle(2);

    // single "1" bit
    p0 = pulses;
    start_frame();
    acc(1, 0);
    check("model_1", 32'(crc_model(mq)), 32'h4599);
    transmit(0, 16);
    check("value_1", 32'(crc_value), 32'h4599);
    check("seq_1", 32'(packed_obs()), 32'({15'h4599, 1'b1}));
    check("pulses_1", pulses - p0, 1);

    // "1","0"
    start_frame();
    acc(1, 0);
    acc(0, 0);
    check("model_10", 32'(crc_model(mq)), 32'h4EAB);
    transmit(0, 16);
    check("value_10", 32'(crc_value), 32'h4EAB);
    check("seq_10", 32'(packed_obs()), 32'({15'h4EAB, 1'b1}));

    // remote frame: 19 zero bits
    start_frame();
    for (int i = 0; i < 19; i++) acc(0, 0);
    transmit(0, 16);
    check("value_zero", 32'(crc_value), 32'h0);
    check("seq_zero", 32'(packed_obs()), 32'h0001);

    // stuffed strobes in accumulation and transmission
    p0 = pulses;
    start_frame();
    acc(1, 0);
    acc(0, 1);
    transmit(3, 16);
    check("value_stuff", 32'(crc_value), 32'h4599);
    check("seq_stuff", 32'(packed_obs()), 32'({15'h4599, 1'b1}));
    check("pulses_stuff", pulses - p0, 1);

    // abort with frame_start at bit_counter 7, then a full frame
    p0 = pulses;
    start_frame();
    acc(1, 0);
    acc(1, 0);
    transmit(0, 7);
    check("cnt_before_abort", 32'(bit_counter), 32'd7);
    start_frame();
    check("value_abort", 32'(crc_value), 32'h0);
    check("pulses_abort", pulses - p0, 0);
    acc(1, 0);
    acc(0, 0);
    transmit(0, 16);
    check("value_after_abort", 32'(crc_value), 32'h4EAB);

    // asynchronous reset in DELIMITER
    p0 = pulses;
    start_frame();
    acc(1, 0);
    transmit(0, 15);
    reset = 1'b1;
    set_reset_expect();
    #2;
    check("async_rst_bit", 32'(crc_bit), 32'd1);
    check("async_rst_cnt", 32'(bit_counter), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(3);
    check("pulses_rst", pulses - p0, 0);
    start_frame();
    acc(1, 0);
    acc(0, 0);
    transmit(0, 16);
    check("value_after_rst", 32'(crc_value), 32'h4EAB);

    // enable low in DELIMITER
    p0 = pulses;
    start_frame();
    acc(1, 0);
    transmit(0, 15);
    enable = 1'b0;
    idle(1);
    set_reset_expect();
    step(1, 0, 0, 0, 0);
    idle(1);
    enable = 1'b1;
    idle(2);
    check("pulses_en", pulses - p0, 0);
    start_frame();
    acc(1, 0);
    transmit(0, 16);
    check("value_after_en", 32'(crc_value), 32'h4599);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_field.md
Name: crc_field

Overview:
- Downstream neighbour of the data field stage in the CAN transmit frame path.
- Accumulates the CAN CRC-15 over the de-stuffed frame bits, from SOF through the last data bit.
- On data_complete it serialises the 15-bit CRC MSB-first, then the recessive CRC delimiter, and pulses crc_complete to start the ACK field stage.

Parameters:
CRC_POLY, 15'h4599, CAN CRC-15 generator polynomial (x^15 term implicit)
CRC_WIDTH, 15, CRC length in bits; the design is only required to work at 15

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  block enable; low forces IDLE and reset output values on the next clock
sample_point  input  1  one-cycle bit-time strobe
stuff_bit_inserted  input  1  current bit time is a stuff bit; no CRC update or shift
frame_start  input  1  one-cycle pulse at SOF; clears the CRC and starts accumulation
frame_bit  input  1  unstuffed frame bit valid at the current sample point (SOF..data)
data_complete  input  1  pulse from the data field: last data bit done (also pulsed for remote frames)
crc_bit  output  1  serial CRC/delimiter bit; recessive (1) when idle
crc_value  output  15  live CRC register
bit_counter  output  4  CRC bits transmitted so far (0..15)
crc_complete  output  1  one-cycle pulse after the delimiter bit time

Behaviour:
- Reset (async, reset=1): state IDLE, crc_reg=0, shift_reg=0, crc_bit=1, crc_value=0, bit_counter=0, crc_complete=0.
- enable=0 at a clock edge: same values as reset, applied synchronously.
- Qualified bit (qbit) = sample_point && !stuff_bit_inserted.
- CRC update on qbit while in ACCUMULATE:
  - nxt = frame_bit ^ crc_reg[14]
  - crc_reg = {crc_reg[13:0],1'b0} ^ (nxt ? CRC_POLY : 0)
- States:
  - IDLE: crc_bit=1, crc_complete=0. frame_start -> ACCUMULATE with crc_reg=0. The SOF bit is accumulated at its own qbit while in ACCUMULATE, so frame_start must precede the SOF sample point by at least one cycle.
  - ACCUMULATE: update CRC on each qbit. data_complete -> LOAD_CRC. If data_complete and qbit arrive in the same cycle, data_complete wins and that bit is not accumulated.
  - LOAD_CRC (1 cycle): shift_reg<=crc_reg, crc_bit<=crc_reg[14], bit_counter<=0 -> TRANSMIT_CRC.
  - TRANSMIT_CRC: on each qbit, shift_reg shifts left, bit_counter+1, crc_bit<=next MSB. On the qbit where bit_counter==14: bit_counter<=15, crc_bit<=1 -> DELIMITER. Between qbits, crc_bit holds its value.
  - DELIMITER: crc_bit=1. Next qbit -> COMPLETE.
  - COMPLETE (1 cycle): crc_complete=1, crc_bit=1 -> IDLE. bit_counter holds 15 until IDLE clears it to 0.
- crc_value tracks crc_reg. It is frozen from LOAD_CRC onward and cleared only by frame_start, reset or enable=0.
- crc_bit never changes except on a qbit or on the LOAD_CRC cycle, so it is stable across bit times.
- frame_start in any non-IDLE state aborts the frame: crc_reg=0, bit_counter=0, crc_bit=1, -> ACCUMULATE.
- sample_point with stuff_bit_inserted=1: no CRC update, no shift, no count, in every state.
- data_complete outside ACCUMULATE: ignored.
- Reset asserted mid-transmission: immediate return to reset values; no crc_complete pulse.

Test Plan:
- Reset, then frame_start, then 1 qbit with frame_bit=1, then data_complete -> crc_value=15'h4599; crc_bit sequence 1,0,0,0,1,0,1,1,0,0,1,1,0,0,1, then delimiter 1; crc_complete pulses once; bit_counter ends at 15.
- frame_start, bits "1","0", data_complete -> crc_value=15'h4EAB; 15 serial bits match 4EAB MSB-first.
- frame_start, 19 zero bits (SOF..DLC, remote frame), data_complete -> crc_value=0; 15 zeros, then 1, then crc_complete.
- Stream "1" with a qbit carrying stuff_bit_inserted=1 and frame_bit=0 in the middle of accumulation, and 3 stuffed strobes during TRANSMIT_CRC -> crc_value still 15'h4599; bit_counter advances only on unstuffed strobes.
- frame_start pulsed at bit_counter=7 during TRANSMIT_CRC -> crc_value=0, crc_bit=1, state ACCUMULATE, no crc_complete.
- reset (or enable=0) asserted in DELIMITER -> crc_bit=1, bit_counter=0, crc_complete stays 0; the next frame computes correctly.
